// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// One iteration per clock on operand magnitudes; the sign is applied when the result is loaded.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);
    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] v);
        return {{HW{v[HW-1]}}, v[HW-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opb;
    logic [2:0]      op_r;
    logic            word_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic [4:0]      rd_r;
    logic [CW-1:0]   cnt;

    // Operand decode at issue: sign/zero extension, magnitudes, division fast paths.
    logic            a_sgn, b_sgn, s1, s2, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, special_res;

    always_comb begin
        a_sgn = funct3[2] ? ~funct3[0] : (~is_word & (funct3[1:0] != 2'b11));
        b_sgn = funct3[2] ? ~funct3[0] : (~is_word & ~funct3[1]);
        if (is_word) begin
            a_ext = a_sgn ? sext_half(rs1_val) : {{HW{1'b0}}, rs1_val[HW-1:0]};
            b_ext = b_sgn ? sext_half(rs2_val) : {{HW{1'b0}}, rs2_val[HW-1:0]};
        end else begin
            a_ext = rs1_val;
            b_ext = rs2_val;
        end
        s1    = a_sgn & a_ext[XLEN-1];
        s2    = b_sgn & b_ext[XLEN-1];
        a_mag = cond_neg(a_ext, s1);
        b_mag = cond_neg(b_ext, s2);
        div_zero = funct3[2] & (b_ext == '0);
        // W-form overflow falls out of the iteration correctly, so only the full width is short-cut.
        div_ovf  = funct3[2] & ~is_word & ~funct3[0]
                 & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_val);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = funct3[1] ? a_ext : '1;
        else          special_res = funct3[1] ? '0 : a_ext;
        if (is_word) special_res = sext_half(special_res);
    end

    // One iteration step, shared registers: hi/lo are acc/multiplier or remainder/quotient.
    logic            last;
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   sum, sh, hi_nx;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] lo_nx;

    always_comb begin
        last   = word_r ? (cnt == CW'(HW - 1)) : (cnt == CW'(XLEN - 1));
        addend = lo[0] ? opb : '0;
        sum    = hi + {1'b0, addend};
        sh     = {hi[XLEN-1:0], lo[XLEN-1]};
        diff   = {1'b0, sh} - {2'b00, opb};
        if (op_r[2]) begin
            if (!diff[XLEN+1]) begin
                hi_nx = diff[XLEN:0];
                lo_nx = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = sh;
                lo_nx = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx = {1'b0, sum[XLEN:1]};
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, calc_res;

    always_comb begin
        prod = {hi_nx[XLEN-1:0], lo_nx};
        if (neg_q_r) prod = -prod;
        quo = cond_neg(lo_nx, neg_q_r);
        rem = cond_neg(hi_nx[XLEN-1:0], neg_r_r);
        if (op_r[2]) begin
            calc_res = op_r[1] ? rem : quo;
            if (word_r) calc_res = sext_half(calc_res);
        end else if (word_r) begin
            calc_res = sext_half({{HW{1'b0}}, lo_nx[XLEN-1 -: HW]});
        end else begin
            calc_res = (op_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1 -: XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !kill) state_nx = special ? DONE : CALC;
            CALC:    if (kill) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        wb_en = (state == DONE) && !kill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            op_r    <= '0;
            word_r  <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            rd_r    <= '0;
            cnt     <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                IDLE: if (start && !kill) begin
                    op_r    <= funct3;
                    word_r  <= is_word;
                    neg_q_r <= s1 ^ s2;
                    neg_r_r <= s1;
                    rd_r    <= rd_in;
                    cnt     <= '0;
                    hi      <= '0;
                    if (funct3[2]) begin
                        // W-form dividend sits in the top half so quotient bits fill the low half.
                        lo  <= is_word ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
                        opb <= b_mag;
                    end else begin
                        lo  <= b_mag;
                        opb <= a_mag;
                    end
                    if (special) begin
                        wb_data <= special_res;
                        wb_rd   <= rd_in;
                    end
                end
                CALC: if (!kill) begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        wb_data <= calc_res;
                        wb_rd   <= rd_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
